axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Shares the single AXI write channel (AW/W/B) between two write masters: m0 = D-cache dirty-line writeback (bursts), m1 = uncached store path (single beat).
- Sits between the cache/uncached logic and the top-level AXI port, beside the read-side arbiter.
- Owns a whole write transaction per grant (AW, then all W beats, then B) so beats from different masters never interleave.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.
- LEN_W, 8, AXI burst length field width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mN_awaddr  in  ADDR_W  master N write address (N=0,1; same for all mN_ lines)
- mN_awlen  in  LEN_W  beats-1
- mN_awsize  in  3  beat size
- mN_awvalid  in  1  write request
- mN_awready  out  1  request accepted
- mN_wdata  in  DATA_W  write data
- mN_wstrb  in  DATA_W/8  byte enables
- mN_wvalid  in  1  data valid
- mN_wready  out  1  data accepted
- mN_bvalid  out  1  write response to master
- mN_bready  in  1  master accepts response
- awid  out  4  {3'b0, grant}
- awaddr  out  ADDR_W  latched address
- awlen  out  LEN_W  latched length
- awsize  out  3  latched size
- awburst  out  2  constant 2'b01 (INCR)
- awvalid  out  1
- awready  in  1
- wid  out  4  {3'b0, grant}
- wdata  out  DATA_W
- wstrb  out  DATA_W/8
- wlast  out  1  generated from beat counter
- wvalid  out  1
- wready  in  1
- bid  in  4  unused, ignored
- bresp  in  2  unused, ignored
- bvalid  in  1
- bready  out  1
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, grant=0, last_grant=1 (so m0 wins the first tie), beat_cnt=0. awvalid, wvalid, bready, all mN_awready, mN_wready and mN_bvalid are 0. Latched AW fields are 0.
- Reset asserted mid-transaction aborts immediately to the reset state; there is no recovery of the in-flight burst.
- FSM states: IDLE, AW, W, B.
- IDLE: if any mN_awvalid is high, choose a winner.
  - Only one requester: it wins.
  - Both requesting: round-robin, the master not equal to last_grant wins.
  - On the winning edge: latch awaddr/awlen/awsize into registers, set grant, pulse the winner's mN_awready for exactly this cycle (the master's AW handshake completes in IDLE), go to AW.
  - No requester: stay in IDLE.
- AW: awvalid=1, driving the latched fields (stable regardless of master inputs). On awready: go to W, beat_cnt=0.
- W: wvalid = mG_wvalid, mG_wready = wready (G = grant), wdata/wstrb pass through combinationally from mG.
  - The non-granted master sees mN_wready=0.
  - wlast = (beat_cnt == awlen_latched).
  - Each wvalid&wready increments beat_cnt.
  - On the handshake where wlast=1: go to B.
  - Master wlast is not used.
- B: bready = mG_bready, mG_bvalid = bvalid; the other master's bvalid is 0. On bvalid&bready: last_grant=grant, go to IDLE.
- One transaction outstanding at a time. Minimum transaction is IDLE→AW→W→B→IDLE, i.e. 4 cycles for a single beat with zero-wait slave.
- A request that arrives during a non-IDLE state waits; mN_awready stays 0.
- A master that drops mN_awvalid before the grant is simply not considered.
- awlen=0: the first W beat has wlast=1.
- awlen=255: beat_cnt wraps-safe. It is LEN_W wide and compares equal at 255, never overflowing before wlast.
- awid and wid reflect the registered grant in every state. Outside W, wdata=0 and wstrb=0.

Test Plan:
- Single m1 write, addr 0x1FAF_0000, len 0, data 0xDEADBEEF, strb 4'hF, zero-wait slave -> awvalid 1 cycle with awid=1, one W beat with wlast=1, m1_bvalid on B, busy back to 0 after 4 cycles.
- m0 burst len 7 from 0x0000_1000, wready toggling every other cycle -> exactly 8 W handshakes, wlast only on the 8th, data order preserved, awaddr stable throughout.
- m0 and m1 both assert awvalid in IDLE after reset -> m0 granted first; after its B, m1 granted. Repeat both requesting -> strict alternation.
- m1 asserts awvalid while an m0 burst is in W -> m1_awready stays 0, m1_wready stays 0 until the m0 B handshake completes, then m1 is granted.
- bvalid held while mG_bready=0 for 3 cycles -> state stays B, no new grant; completes on the cycle bready rises.
- rst pulsed asynchronously (between clock edges) during the W state of a len 3 burst -> all outputs drop to 0 without waiting for an edge; state=IDLE; the next request from m0 is granted normally.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// =============================================================================
// axi_wr_arbiter : shares one AXI write channel (AW/W/B) between two masters,
//                  granting a whole transaction at a time with round-robin ties.
// Revision      : 1.0 - initial release
// =============================================================================
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 : D-cache writeback
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [LEN_W-1:0]    m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1 : uncached stores
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [LEN_W-1:0]    m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // shared AXI write port
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_grant;
  logic                r_last_grant;
  logic [LEN_W-1:0]    r_beat_cnt;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [LEN_W-1:0]    r_awlen;
  logic [2:0]          r_awsize;

  logic w_req_any;
  logic w_winner;
  logic w_idle;
  logic w_in_w;
  logic w_in_b;
  logic w_w_hs;
  logic w_last;
  logic w_unused;

  // Response id/status carry nothing the masters need.
  assign w_unused  = ^{bid, bresp};

  assign w_idle    = (r_state == S_IDLE);
  assign w_in_w    = (r_state == S_W);
  assign w_in_b    = (r_state == S_B);
  assign w_req_any = m0_awvalid | m1_awvalid;
  // On a tie the master that did not win last time goes first.
  assign w_winner  = (m0_awvalid & m1_awvalid) ? ~r_last_grant : m1_awvalid;
  assign w_last    = (r_beat_cnt == r_awlen);
  assign w_w_hs    = wvalid & wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awsize     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant  <= w_winner;
            r_awaddr <= w_winner ? m1_awaddr : m0_awaddr;
            r_awlen  <= w_winner ? m1_awlen  : m0_awlen;
            r_awsize <= w_winner ? m1_awsize : m0_awsize;
            r_state  <= S_AW;
          end
        end
        S_AW: begin
          if (awready) begin
            r_beat_cnt <= '0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            if (w_last) r_state <= S_B;
          end
        end
        S_B: begin
          if (bvalid && bready) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Master AW handshake completes in IDLE, on the same edge as the grant.
  assign m0_awready = w_idle & w_req_any & ~w_winner;
  assign m1_awready = w_idle & w_winner;

  assign awid    = {3'b000, r_grant};
  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awvalid = (r_state == S_AW);

  assign wid     = {3'b000, r_grant};
  assign wvalid  = w_in_w & (r_grant ? m1_wvalid : m0_wvalid);
  assign wdata   = w_in_w ? (r_grant ? m1_wdata : m0_wdata) : '0;
  assign wstrb   = w_in_w ? (r_grant ? m1_wstrb : m0_wstrb) : '0;
  assign wlast   = w_in_w & w_last;
  assign m0_wready = w_in_w & ~r_grant & wready;
  assign m1_wready = w_in_w &  r_grant & wready;

  assign bready    = w_in_b & (r_grant ? m1_bready : m0_bready);
  assign m0_bvalid = w_in_b & ~r_grant & bvalid;
  assign m1_bvalid = w_in_b &  r_grant & bvalid;

  assign busy = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// =============================================================================
// tb_axi_wr_arbiter : randomized masters and slave around axi_wr_arbiter,
//                     checked against a transaction-level model.
// Revision          : 1.0 - initial release
// =============================================================================
module tb_axi_wr_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [31:0]       seed;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m_awaddr [2];
  logic [LEN_W-1:0]  m_awlen  [2];
  logic [2:0]        m_awsize [2];
  logic              m_awvalid[2];
  logic              m_awready[2];
  logic [DATA_W-1:0] m_wdata  [2];
  logic [STRB_W-1:0] m_wstrb  [2];
  logic              m_wvalid [2];
  logic              m_wready [2];
  logic              m_bvalid [2];
  logic              m_bready [2];

  logic [3:0]        awid, wid, bid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst, bresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready, busy;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]),
    .m0_wready(m_wready[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]),
    .m1_wready(m_wready[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  job_t pend[2][$];
  job_t expq[2][$];
  int   grant_log[$];

  int aw_rate = 100, w_rate = 100, b_rate = 100, wr_mode = 0;
  bit gaps = 1'b0;
  bit abort = 1'b0;
  int bdelay[2];

  int done_cnt = 0, whs_cnt = 0, wlast_cnt = 0, aw_cycles = 0;
  int busy_cycles = 0, blocked_cycles = 0, bstall_cycles = 0;

  bit   mon_in_txn = 1'b0;
  int   mon_g = 0, mon_phase = 0, mon_beat = 0, mon_rr_last = 1;
  job_t cur;

  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] seed, input int k);
    return seed ^ (32'(k) * 32'h9E37_79B9);
  endfunction

  function automatic logic [STRB_W-1:0] beat_strb(input logic [31:0] seed, input int k);
    return seed[3:0] ^ 4'(k);
  endfunction

  // Transaction-level reference: arbitration rule, ownership and beat order.
  logic [1:0] exp_ar;
  int         win;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || abort) begin
        mon_in_txn = 1'b0; mon_rr_last = 1; mon_phase = 0;
        continue;
      end
      exp_ar = 2'b00;
      if (!mon_in_txn && (m_awvalid[0] || m_awvalid[1])) begin
        win = (m_awvalid[0] && m_awvalid[1]) ? 1 - mon_rr_last : (m_awvalid[1] ? 1 : 0);
        exp_ar[win] = 1'b1;
      end
      n_cmp++;
      if ({m_awready[1], m_awready[0]} !== exp_ar) begin
        n_err++; $display("FAIL grant: awready=%b expected %b", {m_awready[1], m_awready[0]}, exp_ar);
      end
      n_cmp++;
      if (busy !== mon_in_txn) begin
        n_err++; $display("FAIL busy: got %b expected %b", busy, mon_in_txn);
      end
      if (busy) busy_cycles++;
      if (mon_in_txn) begin
        if (m_awvalid[1-mon_g]) blocked_cycles++;
        if (awvalid) aw_cycles++;
        n_cmp++;
        if ({awid, awaddr, awlen, awsize, awburst} !== {4'(mon_g), cur.addr, cur.len, cur.size, 2'b01}) begin
          n_err++; $display("FAIL aw_fields: id=%h addr=%h len=%0d size=%0d burst=%b expected id=%0d addr=%h len=%0d size=%0d",
                            awid, awaddr, awlen, awsize, awburst, mon_g, cur.addr, cur.len, cur.size);
        end
        n_cmp++;
        if ({m_wready[1-mon_g], m_bvalid[1-mon_g], awvalid} !== {2'b00, 1'(mon_phase == 0)}) begin
          n_err++; $display("FAIL phase_ctrl: other wready/bvalid=%b%b awvalid=%b expected 00 %b",
                            m_wready[1-mon_g], m_bvalid[1-mon_g], awvalid, mon_phase == 0);
        end
        if (mon_phase != 1) begin
          n_cmp++;
          if ({wvalid, wdata, wstrb} !== '0) begin
            n_err++; $display("FAIL w_outside: wvalid=%b wdata=%h wstrb=%h expected 0", wvalid, wdata, wstrb);
          end
        end
        case (mon_phase)
          0: if (awvalid && awready) begin mon_phase = 1; mon_beat = 0; end
          1: begin
            n_cmp++;
            if ({wvalid, m_wready[mon_g]} !== {m_wvalid[mon_g], wready}) begin
              n_err++; $display("FAIL w_route: wvalid=%b mwready=%b expected %b %b", wvalid, m_wready[mon_g], m_wvalid[mon_g], wready);
            end
            if (wvalid && wready) begin
              whs_cnt++;
              if (wlast) wlast_cnt++;
              n_cmp++;
              if ({wid, wdata, wstrb, wlast} !== {4'(mon_g), beat_data(cur.seed, mon_beat),
                                                   beat_strb(cur.seed, mon_beat), 1'(mon_beat == int'(cur.len))}) begin
                n_err++; $display("FAIL w_beat%0d: id=%h data=%h strb=%h last=%b expected id=%0d data=%h strb=%h last=%b",
                                  mon_beat, wid, wdata, wstrb, wlast, mon_g, beat_data(cur.seed, mon_beat),
                                  beat_strb(cur.seed, mon_beat), mon_beat == int'(cur.len));
              end
              if (mon_beat == int'(cur.len)) mon_phase = 2;
              else mon_beat++;
            end
          end
          default: begin
            n_cmp++;
            if ({bready, m_bvalid[mon_g]} !== {m_bready[mon_g], bvalid}) begin
              n_err++; $display("FAIL b_route: bready=%b mbvalid=%b expected %b %b", bready, m_bvalid[mon_g], m_bready[mon_g], bvalid);
            end
            if (bvalid && !bready) bstall_cycles++;
            if (bvalid && bready) begin
              mon_in_txn = 1'b0; mon_rr_last = mon_g; done_cnt++;
            end
          end
        endcase
      end else begin
        n_cmp++;
        if ({awvalid, wvalid, bready, wdata, wstrb} !== '0) begin
          n_err++; $display("FAIL idle_outputs: awvalid=%b wvalid=%b bready=%b wdata=%h", awvalid, wvalid, bready, wdata);
        end
        for (int n = 0; n < 2; n++) begin
          if (m_awready[n] && m_awvalid[n]) begin
            mon_in_txn = 1'b1; mon_g = n; mon_phase = 0;
            grant_log.push_back(n);
            n_cmp++;
            if (expq[n].size() == 0) begin
              n_err++; $display("FAIL unexpected_grant: master %0d granted with queue size 0 expected >0", n);
            end else begin
              cur = expq[n].pop_front();
            end
          end
        end
      end
    end
  end

  // Slave: random ready, one buffered response.
  bit wl_s, bh_s, pend_b;
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; pend_b = 1'b0;
    bid = 4'hA; bresp = 2'b10;
    forever begin
      @(negedge clk);
      wl_s = wvalid & wready & wlast;
      bh_s = bvalid & bready;
      @(posedge clk); #1;
      if (rst || abort) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; pend_b = 1'b0;
        continue;
      end
      if (bh_s) bvalid = 1'b0;
      if (wl_s) pend_b = 1'b1;
      if (pend_b && !bvalid && $urandom_range(0, 99) < b_rate) begin
        bvalid = 1'b1; pend_b = 1'b0;
      end
      awready = ($urandom_range(0, 99) < aw_rate);
      if (wr_mode == 1) wready = ~wready;
      else wready = ($urandom_range(0, 99) < w_rate);
    end
  end

  task automatic master_drv(input int n);
    job_t j;
    int   bd;
    forever begin
      @(posedge clk); #1;
      if (abort || pend[n].size() == 0) continue;
      j = pend[n].pop_front();
      m_awaddr[n] = j.addr; m_awlen[n] = j.len; m_awsize[n] = j.size; m_awvalid[n] = 1'b1;
      do @(negedge clk); while (!m_awready[n] && !abort);
      @(posedge clk); #1;
      m_awvalid[n] = 1'b0;
      for (int k = 0; k <= int'(j.len) && !abort; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          m_wvalid[n] = 1'b0; @(posedge clk); #1;
        end
        m_wvalid[n] = 1'b1; m_wdata[n] = beat_data(j.seed, k); m_wstrb[n] = beat_strb(j.seed, k);
        do @(negedge clk); while (!m_wready[n] && !abort);
        @(posedge clk); #1;
      end
      m_wvalid[n] = 1'b0; m_wdata[n] = '0; m_wstrb[n] = '0;
      bd = bdelay[n];
      if (!abort) begin
        m_bready[n] = (bd == 0);
        do @(negedge clk); while (!m_bvalid[n] && !abort);
        if (bd > 0) begin
          repeat (bd) @(posedge clk);
          #1 m_bready[n] = 1'b1;
          @(negedge clk);
        end
        @(posedge clk); #1;
      end
      m_awvalid[n] = 1'b0; m_bready[n] = 1'b0;
    end
  endtask

  initial master_drv(0);
  initial master_drv(1);

  task automatic push_job(input int n, input logic [31:0] addr, input int len, input logic [31:0] seed);
    job_t j;
    j.addr = addr; j.len = LEN_W'(len); j.size = 3'd2; j.seed = seed;
    pend[n].push_back(j);
    expq[n].push_back(j);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (mon_in_txn && mon_phase == ph) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_slave(input int a, input int w, input int b, input int mode, input bit g);
    aw_rate = a; w_rate = w; b_rate = b; wr_mode = mode; gaps = g;
    bdelay[0] = 0; bdelay[1] = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, bready, busy, wlast, m_awready[0], m_awready[1], m_wready[0], m_wready[1],
         m_bvalid[0], m_bvalid[1], awid, awaddr, awlen, awsize, wdata, wstrb} !== '0) begin
      n_err++; $display("FAIL reset_state: awvalid=%b wvalid=%b bready=%b busy=%b awid=%h awaddr=%h awlen=%h expected all 0",
                        awvalid, wvalid, bready, busy, awid, awaddr, awlen);
    end
    @(posedge clk); #3 rst = 1'b0;
  endtask

  task automatic test_alternation();
    bit ok;
    int base = grant_log.size();
    set_slave(100, 100, 100, 0, 1'b0);
    @(negedge clk);
    push_job(0, 32'h0000_2000, 1, $urandom);
    push_job(1, 32'h1FAF_0100, 0, $urandom);
    push_job(0, 32'h0000_2040, 2, $urandom);
    push_job(1, 32'h1FAF_0104, 0, $urandom);
    wait_done(done_cnt + 4, 200, ok);
    n_cmp++;
    if (!ok || grant_log.size() != base + 4) begin
      n_err++; $display("FAIL alternation_done: ok=%b grants=%0d expected 4", ok, grant_log.size() - base);
    end else begin
      n_cmp++;
      if ({grant_log[base], grant_log[base+1], grant_log[base+2], grant_log[base+3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
        n_err++; $display("FAIL alternation_order: got %0d%0d%0d%0d expected 0101",
                          grant_log[base], grant_log[base+1], grant_log[base+2], grant_log[base+3]);
      end
    end
  endtask

  task automatic test_single_m1();
    bit ok;
    int base = done_cnt;
    set_slave(100, 100, 100, 0, 1'b0);
    repeat (2) @(negedge clk);
    busy_cycles = 0; aw_cycles = 0; whs_cnt = 0; wlast_cnt = 0;
    push_job(1, 32'h1FAF_0000, 0, 32'hDEAD_BEEF);
    wait_done(base + 1, 50, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || {busy_cycles, aw_cycles, whs_cnt, wlast_cnt} !== {32'd3, 32'd1, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL single_m1: ok=%b busy_cyc=%0d aw_cyc=%0d beats=%0d lasts=%0d expected 3 1 1 1",
                        ok, busy_cycles, aw_cycles, whs_cnt, wlast_cnt);
    end
  endtask

  task automatic test_burst_m0();
    bit ok;
    int base = done_cnt;
    set_slave(100, 100, 100, 1, 1'b0);
    whs_cnt = 0; wlast_cnt = 0;
    push_job(0, 32'h0000_1000, 7, $urandom);
    wait_done(base + 1, 200, ok);
    n_cmp++;
    if (!ok || whs_cnt != 8 || wlast_cnt != 1) begin
      n_err++; $display("FAIL burst_m0: ok=%b beats=%0d lasts=%0d expected 8 1", ok, whs_cnt, wlast_cnt);
    end
  endtask

  task automatic test_blocked();
    bit ok;
    int base = done_cnt;
    int gl = grant_log.size();
    set_slave(100, 60, 100, 0, 1'b1);
    blocked_cycles = 0;
    push_job(0, 32'h0000_3000, 3, $urandom);
    wait_phase(1, 100, ok);
    push_job(1, 32'h1FAF_0200, 1, $urandom);
    wait_done(base + 2, 300, ok);
    n_cmp++;
    if (!ok || grant_log.size() != gl + 2 || blocked_cycles == 0) begin
      n_err++; $display("FAIL blocked_done: ok=%b grants=%0d blocked=%0d expected 2 >0", ok, grant_log.size() - gl, blocked_cycles);
    end else begin
      n_cmp++;
      if ({grant_log[gl], grant_log[gl+1]} !== {32'd0, 32'd1}) begin
        n_err++; $display("FAIL blocked_order: got %0d%0d expected 01", grant_log[gl], grant_log[gl+1]);
      end
    end
  endtask

  task automatic test_b_stall();
    bit ok;
    int base = done_cnt;
    set_slave(100, 100, 100, 0, 1'b0);
    bdelay[0] = 3;
    bstall_cycles = 0;
    push_job(0, 32'h0000_4000, 0, $urandom);
    wait_phase(2, 100, ok);
    push_job(1, 32'h1FAF_0300, 0, $urandom);
    wait_done(base + 2, 200, ok);
    n_cmp++;
    if (!ok || bstall_cycles != 3) begin
      n_err++; $display("FAIL b_stall: ok=%b stall_cycles=%0d expected 3", ok, bstall_cycles);
    end
    bdelay[0] = 0;
  endtask

  task automatic test_random();
    bit ok;
    int base = done_cnt;
    int total = 24;
    set_slave($urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100), 0, 1'b1);
    bdelay[0] = $urandom_range(0, 2); bdelay[1] = $urandom_range(0, 2);
    push_job(0, 32'h0001_0000, 255, $urandom);
    for (int i = 1; i < total; i++)
      push_job($urandom_range(0, 1), $urandom & 32'hFFFF_FFF0, $urandom_range(0, 15), $urandom);
    wait_done(base + total, 20000, ok);
    n_cmp++;
    if (!ok || expq[0].size() != 0 || expq[1].size() != 0) begin
      n_err++; $display("FAIL random: ok=%b done=%0d left=%0d/%0d expected %0d 0/0",
                        ok, done_cnt - base, expq[0].size(), expq[1].size(), total);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int base, gl;
    set_slave(100, 100, 100, 0, 1'b0);
    push_job(0, 32'h0000_5000, 3, $urandom);
    wait_phase(1, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL async_reach_w: ok=%b expected 1", ok);
    end
    @(posedge clk); #3;
    abort = 1'b1; rst = 1'b1;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, wlast, bready, busy, m_awready[0], m_awready[1], m_wready[0], m_wready[1],
         m_bvalid[0], m_bvalid[1], awaddr, awlen, awsize, wdata, wstrb} !== '0) begin
      n_err++; $display("FAIL async_reset: awvalid=%b wvalid=%b wlast=%b busy=%b awaddr=%h wdata=%h expected all 0",
                        awvalid, wvalid, wlast, busy, awaddr, wdata);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #3;
    pend[0].delete(); pend[1].delete(); expq[0].delete(); expq[1].delete();
    abort = 1'b0;
    base = done_cnt; gl = grant_log.size();
    push_job(0, 32'h0000_6000, 1, $urandom);
    wait_done(base + 1, 100, ok);
    n_cmp++;
    if (!ok || grant_log.size() != gl + 1 || grant_log[gl] != 0) begin
      n_err++; $display("FAIL after_reset: ok=%b grants=%0d expected 1 to master 0", ok, grant_log.size() - gl);
    end
  endtask

  initial begin
    rst = 1'b1;
    bdelay[0] = 0; bdelay[1] = 0;
    for (int n = 0; n < 2; n++) begin
      m_awaddr[n] = '0; m_awlen[n] = '0; m_awsize[n] = '0; m_awvalid[n] = 1'b0;
      m_wdata[n] = '0; m_wstrb[n] = '0; m_wvalid[n] = 1'b0; m_bready[n] = 1'b0;
    end
    test_reset();
    test_alternation();
    test_single_m1();
    test_burst_m0();
    test_blocked();
    test_b_stall();
    test_random();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
